// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage.
// Contents:
//   lsu_state_t             FSM state encoding of the stage controller
//   RMASK_B/H/W             load width masks as delivered by the execute stage
//   AXI_RESP_OKAY/SLVERR/DECERR   data-bus response codes
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } lsu_state_t;

  localparam logic [31:0] RMASK_B = 32'h0000_00FF;
  localparam logic [31:0] RMASK_H = 32'h0000_FFFF;
  localparam logic [31:0] RMASK_W = 32'hFFFF_FFFF;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner.
// Moves the addressed byte lane of a bus word down to bit 0, trims it to the
// requested width and optionally sign-extends it.
// Ports:
//   rdata      in   32  raw word returned by the data bus
//   offset     in   2   byte offset of the load address inside the word
//   rmask      in   32  width mask (byte, half or word)
//   is_signed  in   1   sign-extend byte/half results
//   value      out  32  aligned, extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [31:0] rmask,
  input  logic        is_signed,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [31:0] masked;

  // Misaligned half/word loads are not split across two bus words: whatever
  // falls off the top of the shift simply reads back as zero.  The sign bit
  // is taken from the top of the trimmed field, so only byte and half loads
  // can be extended; a full word passes through untouched.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    masked  = shifted & rmask;
    value   = masked;
    if (is_signed) begin
      if (rmask == RMASK_B) begin
        value = {{24{masked[7]}}, masked[7:0]};
      end else if (rmask == RMASK_H) begin
        value = {{16{masked[15]}}, masked[15:0]};
      end
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage between execute and writeback.
// Accepts one op at a time from execute, performs at most one data-bus read
// or write, then holds the writeback value until writeback takes it.
// Ports:
//   clk, rst_n                              clock / async active-low reset
//   lsu_receive_valid, lsu_send_ready       handshake with execute
//   lsu_send_valid, lsu_receive_ready       handshake with writeback
//   alu_result_in, rsb_in                   address/result and store data
//   ren_in, wen_in, wmask_in, rmask_in, mem_signed_in   access control
//   reg_write_en_in, rd_in, pc_in           fields carried to writeback
//   wb_data, reg_write_en, rd, pc           writeback outputs
//   lsu_fault                               bus error seen for the held op
//   ar*/r*/aw*/w*/b*                        AXI4-Lite-style data bus master
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_receive_valid,
  output logic            lsu_send_ready,
  output logic            lsu_send_valid,
  input  logic            lsu_receive_ready,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] rsb_in,
  input  logic            ren_in,
  input  logic            wen_in,
  input  logic [7:0]      wmask_in,
  input  logic [XLEN-1:0] rmask_in,
  input  logic            mem_signed_in,
  input  logic            reg_write_en_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] wb_data,
  output logic            reg_write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc,
  output logic            lsu_fault,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] awaddr,
  output logic            awvalid,
  input  logic            awready,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  lsu_state_t state, state_next;

  logic [31:0] addr_q;
  logic [31:0] rsb_q;
  logic [3:0]  wmask_q;
  logic [31:0] rmask_q;
  logic        sgn_q;
  logic        is_load_q;
  logic        rwe_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] load_value;
  logic        aw_fire;
  logic        w_fire;
  logic        unused_wmask;

  assign unused_wmask = ^wmask_in[7:4];
  assign aw_fire      = awvalid && awready;
  assign w_fire       = wvalid && wready;

  lsu_load_align u_align (
    .rdata     (rdata_q),
    .offset    (addr_q[1:0]),
    .rmask     (rmask_q),
    .is_signed (sgn_q),
    .value     (load_value)
  );

  // State register.  Reset drops any bus transaction on the floor; the slave
  // is expected to be reset alongside this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus/handshake outputs.  A store takes priority over a load
  // when both request bits are set.  The two write channels may complete in
  // either order; the done flags remember which one has already handshaken
  // so its valid can drop while the other channel is still stalled.
  always_comb begin
    state_next     = state;
    lsu_send_ready = 1'b0;
    lsu_send_valid = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    case (state)
      IDLE: begin
        lsu_send_ready = 1'b1;
        if (lsu_receive_valid) begin
          if (wen_in) begin
            state_next = WR_REQ;
          end else if (ren_in) begin
            state_next = RD_ADDR;
          end else begin
            state_next = DONE;
          end
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          state_next = DONE;
        end
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        lsu_send_valid = 1'b1;
        if (lsu_receive_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Op capture and bus result latching.  Everything the op needs is copied on
  // accept so execute is free to move on; the response code is cleared at the
  // same time so a previous fault never leaks into the next op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rsb_q     <= '0;
      wmask_q   <= '0;
      rmask_q   <= '0;
      sgn_q     <= 1'b0;
      is_load_q <= 1'b0;
      rwe_q     <= 1'b0;
      rd_q      <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= AXI_RESP_OKAY;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_receive_valid) begin
            addr_q    <= alu_result_in;
            rsb_q     <= rsb_in;
            wmask_q   <= wmask_in[3:0];
            rmask_q   <= rmask_in;
            sgn_q     <= mem_signed_in;
            is_load_q <= ren_in && !wen_in;
            rwe_q     <= reg_write_en_in;
            rd_q      <= rd_in;
            pc_q      <= pc_in;
            rdata_q   <= '0;
            resp_q    <= AXI_RESP_OKAY;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rdata_q <= rdata;
            resp_q  <= rresp;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            w_done <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            resp_q <= bresp;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus addresses are always word aligned; store data and strobes are moved
  // up into the byte lanes selected by the low address bits.
  assign araddr = {addr_q[31:2], 2'b00};
  assign awaddr = {addr_q[31:2], 2'b00};
  assign wdata  = rsb_q << {addr_q[1:0], 3'b000};
  assign wstrb  = wmask_q << addr_q[1:0];

  assign wb_data      = is_load_q ? load_value : addr_q;
  assign reg_write_en = rwe_q;
  assign rd           = rd_q;
  assign pc           = pc_q;
  assign lsu_fault    = (state == DONE) && (resp_q != AXI_RESP_OKAY);

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage: table of directed ops, randomized ops checked
// against a behavioural model, and a reset-during-read sequence.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_receive_valid = 1'b0;
  logic        lsu_send_ready;
  logic        lsu_send_valid;
  logic        lsu_receive_ready = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] rsb_in = '0;
  logic        ren_in = 1'b0;
  logic        wen_in = 1'b0;
  logic [7:0]  wmask_in = '0;
  logic [31:0] rmask_in = '0;
  logic        mem_signed_in = 1'b0;
  logic        reg_write_en_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] wb_data;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic        lsu_fault;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
    .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
    .alu_result_in(alu_result_in), .rsb_in(rsb_in), .ren_in(ren_in), .wen_in(wen_in),
    .wmask_in(wmask_in), .rmask_in(rmask_in), .mem_signed_in(mem_signed_in),
    .reg_write_en_in(reg_write_en_in), .rd_in(rd_in), .pc_in(pc_in),
    .wb_data(wb_data), .reg_write_en(reg_write_en), .rd(rd), .pc(pc), .lsu_fault(lsu_fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rsb;
    logic        ren;
    logic        wen;
    logic [7:0]  wmask;
    logic [31:0] rmask;
    logic        sgn;
    logic        rwe;
    logic [4:0]  rdx;
    logic [31:0] pcv;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          arDly;
    int          rDly;
    int          awDly;
    int          wDly;
    int          bDly;
    int          bpDly;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] expWb;
    logic [31:0] expWdata;
    logic [3:0]  expWstrb;
    logic [31:0] expAddr;
    logic        expFault;
    int          expLat;
  } vec_t;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic op_t mkOp(logic [31:0] alu, logic [31:0] rsb, logic ren, logic wen,
                               logic [7:0] wmask, logic [31:0] rmask, logic sgn,
                               logic [31:0] rdv, logic [1:0] resp);
    op_t o;
    o.alu = alu; o.rsb = rsb; o.ren = ren; o.wen = wen; o.wmask = wmask;
    o.rmask = rmask; o.sgn = sgn; o.rdata = rdv; o.resp = resp;
    o.rwe = 1'b0; o.rdx = '0; o.pcv = '0;
    o.arDly = 0; o.rDly = 0; o.awDly = 0; o.wDly = 0; o.bDly = 0; o.bpDly = 0;
    return o;
  endfunction

  function automatic vec_t mkVec(op_t o, logic [31:0] wb, logic [31:0] wd, logic [3:0] ws,
                                 logic [31:0] ad, logic f, int lat);
    vec_t v;
    v.op = o; v.expWb = wb; v.expWdata = wd; v.expWstrb = ws;
    v.expAddr = ad; v.expFault = f; v.expLat = lat;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic on plain integers.
  function automatic logic [31:0] modelLoad(logic [31:0] word, logic [31:0] addr,
                                            logic [31:0] rmask, logic sgn);
    longint unsigned off = longint'(addr % 4);
    longint unsigned v = longint'(word) / (64'd1 << (8 * off));
    longint unsigned nbits = (rmask == 32'hFF) ? 8 : (rmask == 32'hFFFF) ? 16 : 32;
    v = v % (64'd1 << nbits);
    if (sgn && nbits < 32 && v >= (64'd1 << (nbits - 1))) begin
      v = v + (64'd1 << 32) - (64'd1 << nbits);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] modelWdata(logic [31:0] rsbv, logic [31:0] addr);
    longint unsigned v = (longint'(rsbv) * (64'd1 << (8 * (addr % 4)))) % (64'd1 << 32);
    return v[31:0];
  endfunction

  function automatic logic [3:0] modelWstrb(logic [7:0] wmask, logic [31:0] addr);
    logic [3:0] s = '0;
    int off = int'(addr % 4);
    for (int i = 0; i < 4; i++) begin
      if (i >= off && wmask[i - off]) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic vec_t modelVec(op_t o);
    vec_t v;
    int lat;
    logic isLoad = o.ren && !o.wen;
    if (o.wen) lat = 3 + ((o.awDly > o.wDly) ? o.awDly : o.wDly) + o.bDly;
    else if (o.ren) lat = 3 + o.arDly + o.rDly;
    else lat = 1;
    v = mkVec(o,
              isLoad ? modelLoad(o.rdata, o.alu, o.rmask, o.sgn) : o.alu,
              modelWdata(o.rsb, o.alu), modelWstrb(o.wmask, o.alu),
              o.alu - (o.alu % 4), (o.ren || o.wen) && (o.resp != 2'b00), lat);
    return v;
  endfunction

  task automatic driveJunk();
    alu_result_in   = $urandom;
    rsb_in          = $urandom;
    ren_in          = 1'($urandom);
    wen_in          = 1'($urandom);
    wmask_in        = 8'($urandom);
    rmask_in        = $urandom;
    mem_signed_in   = 1'($urandom);
    reg_write_en_in = 1'($urandom);
    rd_in           = 5'($urandom);
    pc_in           = $urandom;
  endtask

  // Runs one op end to end, acting as a delayed-ready bus slave.
  task automatic applyStimulus(input vec_t v, input string tag);
    op_t o = v.op;
    logic isLoad = o.ren && !o.wen;
    int arW = 0, rW = 0, awW = 0, wW = 0, bW = 0;
    int arN = 0, rN = 0, awN = 0, wN = 0, bN = 0;
    int lat = -1;
    @(negedge clk);
    checkOutput({tag, " send_ready idle"}, 32'(lsu_send_ready), 1);
    alu_result_in = o.alu; rsb_in = o.rsb; ren_in = o.ren; wen_in = o.wen;
    wmask_in = o.wmask; rmask_in = o.rmask; mem_signed_in = o.sgn;
    reg_write_en_in = o.rwe; rd_in = o.rdx; pc_in = o.pcv;
    lsu_receive_valid = 1'b1;
    lsu_receive_ready = 1'b0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      driveJunk();
      checkOutput({tag, " send_ready busy"}, 32'(lsu_send_ready), 0);
      if (lsu_send_valid) begin
        lat = k;
      end else begin
        arready = arvalid && (arW >= o.arDly);
        if (arvalid) begin
          if (arready) begin
            arN++;
            checkOutput({tag, " araddr"}, araddr, v.expAddr);
          end
          arW++;
        end
        rvalid = rready && (rW >= o.rDly);
        rdata  = rvalid ? o.rdata : $urandom;
        rresp  = rvalid ? o.resp : 2'($urandom);
        if (rready) begin
          if (rvalid) rN++;
          rW++;
        end
        awready = awvalid && (awW >= o.awDly);
        if (awvalid) begin
          if (awready) begin
            awN++;
            checkOutput({tag, " awaddr"}, awaddr, v.expAddr);
          end
          awW++;
        end
        wready = wvalid && (wW >= o.wDly);
        if (wvalid) begin
          if (wready) begin
            wN++;
            checkOutput({tag, " wdata"}, wdata, v.expWdata);
            checkOutput({tag, " wstrb"}, 32'(wstrb), 32'(v.expWstrb));
          end
          wW++;
        end
        bvalid = bready && (bW >= o.bDly);
        bresp  = bvalid ? o.resp : 2'($urandom);
        if (bready) begin
          if (bvalid) bN++;
          bW++;
        end
      end
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    if (lat < 0) begin
      checkOutput({tag, " send_valid within budget"}, 0, 1);
      lsu_receive_valid = 1'b0;
      return;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, " wb_data"}, wb_data, v.expWb);
    checkOutput({tag, " fault"}, 32'(lsu_fault), 32'(v.expFault));
    checkOutput({tag, " rd"}, 32'(rd), 32'(o.rdx));
    checkOutput({tag, " pc"}, pc, o.pcv);
    checkOutput({tag, " reg_write_en"}, 32'(reg_write_en), 32'(o.rwe));
    checkOutput({tag, " ar handshakes"}, 32'(arN), isLoad ? 1 : 0);
    checkOutput({tag, " r handshakes"}, 32'(rN), isLoad ? 1 : 0);
    checkOutput({tag, " aw handshakes"}, 32'(awN), o.wen ? 1 : 0);
    checkOutput({tag, " w handshakes"}, 32'(wN), o.wen ? 1 : 0);
    checkOutput({tag, " b handshakes"}, 32'(bN), o.wen ? 1 : 0);
    for (int s = 0; s < o.bpDly; s++) begin
      driveJunk();
      lsu_receive_valid = 1'b1;
      @(negedge clk);
      checkOutput({tag, " stall send_valid"}, 32'(lsu_send_valid), 1);
      checkOutput({tag, " stall send_ready"}, 32'(lsu_send_ready), 0);
      checkOutput({tag, " stall wb_data"}, wb_data, v.expWb);
      checkOutput({tag, " stall fault"}, 32'(lsu_fault), 32'(v.expFault));
    end
    lsu_receive_valid = 1'b0;
    lsu_receive_ready = 1'b1;
    @(negedge clk);
    lsu_receive_ready = 1'b0;
    checkOutput({tag, " send_valid after release"}, 32'(lsu_send_valid), 0);
    checkOutput({tag, " send_ready after release"}, 32'(lsu_send_ready), 1);
    checkOutput({tag, " fault after release"}, 32'(lsu_fault), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[13];
    vec_t rv;
    op_t  ro;

    vecs[0]  = mkVec(mkOp(32'h0000_1234, 32'h0, 1'b0, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 2'b00),
                     32'h0000_1234, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    vecs[1]  = mkVec(mkOp(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0000_00FF, 1'b1, 32'h80FF_0000, 2'b00),
                     32'hFFFF_FF80, 32'h0, 4'h0, 32'h8000_0000, 1'b0, 3);
    vecs[2]  = mkVec(mkOp(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0000_00FF, 1'b0, 32'h80FF_0000, 2'b00),
                     32'h0000_0080, 32'h0, 4'h0, 32'h8000_0000, 1'b0, 3);
    vecs[3]  = mkVec(mkOp(32'h8000_0002, 32'h0000_ABCD, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0, 32'h0, 2'b00),
                     32'h8000_0002, 32'hABCD_0000, 4'b1100, 32'h8000_0000, 1'b0, 6);
    vecs[3].op.awDly = 3;
    vecs[4]  = mkVec(mkOp(32'h0000_0010, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 2'b10),
                     32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0000_0010, 1'b1, 3);
    vecs[5]  = mkVec(mkOp(32'h0000_55AA, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 2'b00),
                     32'h0000_55AA, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    vecs[6]  = mkVec(mkOp(32'h0000_0102, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0000_FFFF, 1'b1, 32'h8001_1234, 2'b00),
                     32'hFFFF_8001, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 3);
    vecs[7]  = mkVec(mkOp(32'h0000_0103, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0000_FFFF, 1'b0, 32'hAABB_CCDD, 2'b00),
                     32'h0000_00AA, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 3);
    vecs[8]  = mkVec(mkOp(32'h0000_0020, 32'h1122_3344, 1'b1, 1'b1, 8'h0F, 32'h0000_00FF, 1'b1, 32'hFFFF_FFFF, 2'b00),
                     32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0020, 1'b0, 3);
    vecs[9]  = mkVec(mkOp(32'h0000_0044, 32'hCAFE_F00D, 1'b0, 1'b1, 8'h0F, 32'h0, 1'b0, 32'h0, 2'b11),
                     32'h0000_0044, 32'hCAFE_F00D, 4'hF, 32'h0000_0044, 1'b1, 5);
    vecs[9].op.bDly = 2;
    vecs[10] = mkVec(mkOp(32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 2'b00),
                     32'h0000_BEEF, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    vecs[10].op.bpDly = 5;
    vecs[11] = mkVec(mkOp(32'h0000_0201, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0000_00FF, 1'b1, 32'h0000_7F00, 2'b00),
                     32'h0000_007F, 32'h0, 4'h0, 32'h0000_0200, 1'b0, 6);
    vecs[11].op.arDly = 2;
    vecs[11].op.rDly  = 1;
    vecs[12] = mkVec(mkOp(32'h0000_0003, 32'h0000_00EE, 1'b0, 1'b1, 8'h01, 32'h0, 1'b0, 32'h0, 2'b00),
                     32'h0000_0003, 32'hEE00_0000, 4'b1000, 32'h0000_0000, 1'b0, 3);

    // Reset state
    #1;
    checkOutput("reset send_ready", 32'(lsu_send_ready), 1);
    checkOutput("reset send_valid", 32'(lsu_send_valid), 0);
    checkOutput("reset bus valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    checkOutput("reset wb_data", wb_data, 0);
    checkOutput("reset fault", 32'(lsu_fault), 0);
    checkOutput("reset pc", pc, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed table");
    for (int i = 0; i < 13; i++) begin
      vecs[i].op.rwe = 1'(i % 2);
      vecs[i].op.rdx = 5'(i + 1);
      vecs[i].op.pcv = 32'h0000_1000 + 32'(4 * i);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] randomized ops");
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(3, 0));
      logic [31:0] rm;
      case ($urandom_range(2, 0))
        0: rm = 32'h0000_00FF;
        1: rm = 32'h0000_FFFF;
        default: rm = 32'hFFFF_FFFF;
      endcase
      ro = mkOp($urandom, $urandom, (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                8'($urandom), rm, 1'($urandom), $urandom,
                ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00);
      ro.rwe = 1'($urandom); ro.rdx = 5'($urandom); ro.pcv = $urandom;
      ro.arDly = int'($urandom_range(3, 0)); ro.rDly = int'($urandom_range(3, 0));
      ro.awDly = int'($urandom_range(3, 0)); ro.wDly = int'($urandom_range(3, 0));
      ro.bDly  = int'($urandom_range(3, 0)); ro.bpDly = int'($urandom_range(2, 0));
      rv = modelVec(ro);
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    $display("[TB] reset during read data wait");
    @(negedge clk);
    alu_result_in = 32'h0000_0040; ren_in = 1'b1; wen_in = 1'b0;
    rmask_in = 32'h0000_00FF; mem_signed_in = 1'b0;
    lsu_receive_valid = 1'b1;
    @(negedge clk);
    lsu_receive_valid = 1'b0;
    checkOutput("rst arvalid before", 32'(arvalid), 1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checkOutput("rst rready before", 32'(rready), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst arvalid", 32'(arvalid), 0);
    checkOutput("rst rready", 32'(rready), 0);
    checkOutput("rst send_valid", 32'(lsu_send_valid), 0);
    checkOutput("rst send_ready", 32'(lsu_send_ready), 1);
    checkOutput("rst wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec(mkOp(32'h0000_0777, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 2'b00),
                        32'h0000_0777, 32'h0, 4'h0, 32'h0, 1'b0, 1), "post-reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
